// File: rtl/pc_sequencer.sv
// Instruction-fetch controller: owns the ROM program counter, handles stall/branch
// redirects with a post-branch squash window, halt detection and fetch statistics.
module pc_sequencer #(
    parameter int unsigned PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] HALT_INSTR   = 32'hD440_0000,
    parameter int unsigned MAX_STALL    = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                hazard_pc_write,
    input  logic [PC_WIDTH-1:0] hazard_pc,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_pc,
    input  logic [31:0]         instruction,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_valid,
    output logic                flush,
    output logic                halted,
    output logic                stall_timeout,
    output logic [31:0]         cycle_count,
    output logic [31:0]         fetch_count
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [7:0] STALL_MAX  = 8'(MAX_STALL);

    state_t              state, state_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic [3:0]          flush_cnt, flush_cnt_next;
    logic [7:0]          stall_cnt;
    logic                active;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // Priority: stall > branch > halt (RUN only) > sequential; flush window counts only sequential steps.
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        flush_cnt_next = flush_cnt;
        unique case (state)
            IDLE: begin
                if (enable)
                    state_next = RUN;
            end
            RUN, FLUSH: begin
                if (enable) begin
                    if (hazard_pc_write) begin
                        pc_next = hazard_pc;
                    end else if (branch_taken) begin
                        pc_next        = branch_pc;
                        state_next     = FLUSH;
                        flush_cnt_next = FLUSH_LOAD;
                    end else if (state == RUN && instruction == HALT_INSTR) begin
                        state_next = HALT;
                    end else begin
                        pc_next = pc + PC_WIDTH'(1);
                        if (state == FLUSH) begin
                            if (flush_cnt <= 4'd1) begin
                                state_next     = RUN;
                                flush_cnt_next = '0;
                            end else begin
                                flush_cnt_next = flush_cnt - 4'd1;
                            end
                        end
                    end
                end
            end
            HALT: begin
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        fetch_valid = (state == RUN) && enable;
        flush       = (state == FLUSH);
        halted      = (state == HALT);
    end

    assign active = (state == RUN) || (state == FLUSH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count   <= '0;
            fetch_count   <= '0;
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (active)
                cycle_count <= cycle_count + 32'd1;
            if (fetch_valid && !hazard_pc_write)
                fetch_count <= fetch_count + 32'd1;
            if (active && enable) begin
                if (hazard_pc_write) begin
                    if (stall_cnt != STALL_MAX)
                        stall_cnt <= stall_cnt + 8'd1;
                    if (stall_cnt == STALL_MAX - 8'd1)
                        stall_timeout <= 1'b1;
                end else begin
                    stall_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential fetch, branch flush, stall
// priority, watchdog, enable hold, halt and asynchronous reset.
module tb_pc_sequencer;

    localparam logic [31:0] HALT = 32'hD440_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        hazard_pc_write;
    logic [31:0] hazard_pc;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic        halted;
    logic        stall_timeout;
    logic [31:0] cycle_count;
    logic [31:0] fetch_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pc_sequencer #(
        .PC_WIDTH    (32),
        .RESET_PC    (32'd0),
        .FLUSH_CYCLES(2),
        .HALT_INSTR  (HALT),
        .MAX_STALL   (15)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .hazard_pc_write(hazard_pc_write),
        .hazard_pc      (hazard_pc),
        .branch_taken   (branch_taken),
        .branch_pc      (branch_pc),
        .instruction    (instruction),
        .pc             (pc),
        .fetch_valid    (fetch_valid),
        .flush          (flush),
        .halted         (halted),
        .stall_timeout  (stall_timeout),
        .cycle_count    (cycle_count),
        .fetch_count    (fetch_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; hazard_pc_write = 1'b0; hazard_pc = '0;
        branch_taken = 1'b0; branch_pc = '0; instruction = '0;
        step(2);

        // Reset state
        chk("rst_pc", pc, 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_timeout", 32'(stall_timeout), 32'd0);
        chk("rst_cycles", cycle_count, 32'd0);
        chk("rst_fetches", fetch_count, 32'd0);

        // Sequential fetch
        reset = 1'b1;
        enable = 1'b1;
        step(1);
        chk("idle_to_run_pc", pc, 32'd0);
        chk("run_fetch_valid", 32'(fetch_valid), 32'd1);
        step(3);
        chk("seq_pc3", pc, 32'd3);
        chk("seq_cycles", cycle_count, 32'd3);
        chk("seq_fetches", fetch_count, 32'd3);
        step(2);
        chk("seq_pc5", pc, 32'd5);

        // Branch redirect and squash window; halt word on wrong path is ignored
        branch_taken = 1'b1; branch_pc = 32'h20;
        step(1);
        branch_taken = 1'b0;
        instruction = HALT;
        chk("br_pc", pc, 32'h20);
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("br_fetches", fetch_count, 32'd6);
        step(1);
        chk("fl_pc21", pc, 32'h21);
        chk("fl_flush", 32'(flush), 32'd1);
        chk("fl_not_halted", 32'(halted), 32'd0);
        step(1);
        instruction = '0;
        chk("fl_end_pc", pc, 32'h22);
        chk("fl_end_flush", 32'(flush), 32'd0);
        chk("fl_end_halted", 32'(halted), 32'd0);
        chk("fl_end_fetch_valid", 32'(fetch_valid), 32'd1);
        chk("fl_end_fetches", fetch_count, 32'd6);
        chk("fl_end_cycles", cycle_count, 32'd8);

        // Stall beats branch
        hazard_pc_write = 1'b1; hazard_pc = 32'd7;
        branch_taken = 1'b1; branch_pc = 32'h40;
        step(1);
        hazard_pc_write = 1'b0; branch_taken = 1'b0;
        chk("hz_pc", pc, 32'd7);
        chk("hz_no_flush", 32'(flush), 32'd0);
        chk("hz_fetches", fetch_count, 32'd6);
        step(1);
        chk("hz_resume_pc", pc, 32'd8);

        // Stall watchdog
        hazard_pc_write = 1'b1; hazard_pc = 32'd8;
        step(14);
        chk("wd_pc_held", pc, 32'd8);
        chk("wd_before", 32'(stall_timeout), 32'd0);
        step(1);
        chk("wd_trip", 32'(stall_timeout), 32'd1);
        hazard_pc_write = 1'b0;
        step(1);
        chk("wd_sticky", 32'(stall_timeout), 32'd1);
        chk("wd_resume_pc", pc, 32'd9);
        chk("wd_cycles", cycle_count, 32'd26);
        chk("wd_fetches", fetch_count, 32'd8);

        // enable low in RUN holds pc, cycle_count still runs
        enable = 1'b0;
        step(2);
        chk("en0_pc", pc, 32'd9);
        chk("en0_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("en0_cycles", cycle_count, 32'd28);
        chk("en0_fetches", fetch_count, 32'd8);
        enable = 1'b1;

        // Halt at pc=3
        do_reset();
        chk("rst2_timeout", 32'(stall_timeout), 32'd0);
        step(4);
        chk("pre_halt_pc", pc, 32'd3);
        instruction = HALT;
        step(1);
        instruction = '0;
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", pc, 32'd3);
        chk("halt_fetches", fetch_count, 32'd4);
        chk("halt_cycles", cycle_count, 32'd4);
        branch_taken = 1'b1; branch_pc = 32'h40;
        step(2);
        branch_taken = 1'b0;
        chk("halt_br_pc", pc, 32'd3);
        chk("halt_br_flush", 32'(flush), 32'd0);
        chk("halt_br_cycles", cycle_count, 32'd4);
        chk("halt_br_fetches", fetch_count, 32'd4);

        // Asynchronous reset mid-FLUSH
        do_reset();
        step(2);
        branch_taken = 1'b1; branch_pc = 32'h20;
        step(1);
        branch_taken = 1'b0;
        step(1);
        chk("mid_fl_pc", pc, 32'h21);
        chk("mid_fl_flush", 32'(flush), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_pc", pc, 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_cycles", cycle_count, 32'd0);
        chk("arst_fetches", fetch_count, 32'd0);
        step(1);
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
